// File: rtl/norm_arbiter.sv
// norm_arbiter: round-robin share of one Q16.16 normal-CDF unit among NREQ
// requesters, with a done-or-timeout wait and a one-hot tagged response.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   req_valid/req_d   per-requester request and packed operands
//   req_ready         one-hot accept pulse (ISSUE cycle)
//   resp_valid        one-hot response pulse (RESP cycle)
//   resp_N/resp_err   result and timeout flag, held until next response
//   busy              high whenever the FSM is not in IDLE
//   cdf_start/cdf_d   start pulse and operand to the CDF unit
//   cdf_N/cdf_done    result and completion pulse from the CDF unit
module norm_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_d,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_N,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  cdf_start,
  output logic [WIDTH-1:0]      cdf_d,
  input  logic [WIDTH-1:0]      cdf_N,
  input  logic                  cdf_done
);

  localparam int IW = $clog2(NREQ);

  localparam logic [IW-1:0] LAST_RST =
    IW'(NREQ - 1);
  localparam logic [7:0] TMO_LAST =
    8'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE =
    {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]  resp_n_q, resp_n_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic              cdf_start_q, cdf_start_d;
  logic [WIDTH-1:0]  cdf_d_q, cdf_d_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW:0]       cand;

  // Scan from last_q+1 upward with wrap; the extra
  // bit in cand holds last_q+k before the wrap fix.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!pick_found && req_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // Outputs are registered, so each one is set on the
  // edge that enters the state it belongs to.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    grant_d      = grant_q;
    last_d       = last_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    cdf_start_d  = 1'b0;
    resp_n_d     = resp_n_q;
    resp_err_d   = resp_err_q;
    cdf_d_d      = cdf_d_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          cdf_d_d     = req_d[pick_idx*WIDTH +: WIDTH];
          cdf_start_d = 1'b1;
          req_ready_d = ONE << pick_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        if (cdf_done) begin
          resp_n_d     = cdf_N;
          resp_err_d   = 1'b0;
          resp_valid_d = ONE << grant_q;
          state_d      = RESP;
        end else if (timer_q == TMO_LAST) begin
          resp_n_d     = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = ONE << grant_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      grant_q      <= '0;
      last_q       <= LAST_RST;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_n_q     <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      cdf_start_q  <= 1'b0;
      cdf_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_n_q     <= resp_n_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      cdf_start_q  <= cdf_start_d;
      cdf_d_q      <= cdf_d_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_N     = resp_n_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign cdf_start  = cdf_start_q;
  assign cdf_d      = cdf_d_q;

endmodule
